// File: rtl/inv_shift_sub_stage.sv
// -----------------------------------------------------------------------------
// inv_shift_sub_stage
//
// Purpose:
//   Serialized InvShiftRows + InvSubBytes stage of the AES decryption
//   datapath. It feeds the 128-bit data input of MixColumnsInv. A captured
//   state is turned into one 32-bit output column per clock by a shared bank
//   of inverse S-boxes, one per row. Valid/ready handshakes are used on both
//   the input side and the output side.
//
//   Byte layout (same for data_in and data_out):
//     byte k = 4*col + row occupies bits [127-8k -: 8]
//     column c occupies bits [127-32c -: 32], and row 0 is its MSB byte
//   Function: out[row][c] = InvSbox(in[row][(c - row) mod 4])
//
// Configuration macro:
//   INV_SHIFT_SUB_DUAL_COL_EN - when defined, two columns are produced per
//   cycle with eight S-boxes, so BUSY lasts 2 cycles instead of 4.
//   Handshake, reset and DONE behaviour are the same in both builds.
//
// Parameters:
//   NUM_COLS   columns per AES state; must be 4
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   data_in holds a state to process
//   in_ready   block can accept a state (IDLE only)
//   data_in    input state, column-major
//   out_valid  data_out holds a completed result (DONE only)
//   out_ready  downstream accepts the result
//   data_out   InvSubBytes(InvShiftRows(data_in)), driven from result_reg
//   busy       high while columns are being computed
// -----------------------------------------------------------------------------
module inv_shift_sub_stage #(
    parameter int NUM_COLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    if (NUM_COLS != 4) begin : g_num_cols_check
        $error("inv_shift_sub_stage: NUM_COLS must be 4");
    end

`ifdef INV_SHIFT_SUB_DUAL_COL_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif

    // FIPS-197 inverse S-box, entry 0 in the top byte.
    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        int idx;
        idx = int'(x);
        return INV_SBOX_TABLE[(255 - idx) * 8 +: 8];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [127:0]  r_state_reg;
    logic [127:0]  r_result_reg;
    logic [1:0]    r_col_cnt;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_busy;

    // Captured state split into bytes; index {col, row} equals 4*col + row.
    logic [7:0]    w_state_bytes [16];
    // Output column index handled by each lane this cycle.
    logic [1:0]    w_col_idx     [LANES];
    logic [7:0]    w_sub_byte    [LANES][4];
    logic [31:0]   w_col_out     [LANES];

    for (genvar k = 0; k < 16; k++) begin : g_bytes
        assign w_state_bytes[k] = r_state_reg[127 - 8*k -: 8];
    end

    for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
        assign w_col_idx[lane] = r_col_cnt + 2'(lane);

        for (genvar row = 0; row < 4; row++) begin : g_row
            // InvShiftRows: row r of output column c comes from input
            // column (c - r) mod 4; the 2-bit subtraction wraps for free.
            logic [1:0] w_src_col;
            assign w_src_col = w_col_idx[lane] - 2'(row);
            assign w_sub_byte[lane][row] = inv_sbox(w_state_bytes[{w_src_col, 2'(row)}]);
        end

        assign w_col_out[lane] = {w_sub_byte[lane][0], w_sub_byte[lane][1],
                                  w_sub_byte[lane][2], w_sub_byte[lane][3]};
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_col_cnt    <= 2'd0;
            r_state_reg  <= '0;
            // NOTE: result_reg is reset (not just overwritten later) because
            // data_out is visible at all times and must read zero after reset.
            r_result_reg <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_state_reg <= data_in;
                        r_col_cnt   <= 2'd0;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    for (int lane = 0; lane < LANES; lane++) begin
                        for (int c = 0; c < NUM_COLS; c++) begin
                            if (2'(c) == w_col_idx[lane]) begin
                                r_result_reg[127 - 32*c -: 32] <= w_col_out[lane];
                            end
                        end
                    end
                    r_col_cnt <= r_col_cnt + 2'(LANES);
                    // Last group of columns written this edge: result complete.
                    if (r_col_cnt == 2'(NUM_COLS - LANES)) begin
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    // in_ready rises only after retirement, so a new state is
                    // never accepted in the same cycle the result leaves.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign data_out  = r_result_reg;

endmodule

// File: doc/inv_shift_sub_stage.md
Name: inv_shift_sub_stage

Overview:
Serialized InvShiftRows + InvSubBytes stage of the decryption datapath. It sits directly upstream of MixColumnsInv and feeds that block's 128-bit `data` input. It processes one 32-bit output column per clock through a shared bank of four inverse S-boxes. Valid/ready handshakes are used on both sides.

Parameters:
- NUM_COLS, 4, columns per AES state; fixed at 4 and checked by an elaboration-time error if changed.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  data_in holds a state to process.
- in_ready  output  1  block can accept a state.
- data_in  input  128  input state, column-major.
- out_valid  output  1  data_out holds a completed result.
- out_ready  input  1  downstream (MixColumnsInv side) accepts the result.
- data_out  output  128  InvSubBytes(InvShiftRows(data_in)), same byte layout as data_in.
- busy  output  1  high in BUSY state.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). Polarity and synchronicity are fixed.
- Byte layout:
  - byte index k = 4*col + row, occupying bits [127-8k -: 8].
  - Column c = bits [127-32c -: 32]; row 0 is the MSB byte of the column.
- Function: out[row][c] = InvSbox(in[row][(c - row) mod 4]).
  - InvSbox is the full 256-entry FIPS-197 inverse S-box, combinational.
  - Four instances, one per row.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: capture data_in into state_reg, clear col_cnt to 0, go to BUSY.
  - BUSY:
    - in_ready=0.
    - Each cycle computes output column col_cnt from state_reg and writes it into result_reg column col_cnt.
    - col_cnt increments, 2-bit, wrapping.
    - After writing column 3, go to DONE.
  - DONE:
    - out_valid=1 and data_out=result_reg, held stable until the handshake.
    - On out_ready: go to IDLE, out_valid=0.
    - in_ready=0 in DONE. A new input cannot be taken in the same cycle as output retirement; the earliest new accept is the cycle after the DONE->IDLE transition.
- Latency: accept edge E0; columns written at edges E1..E4; out_valid high from E4. Throughput is 1 state per 6 cycles minimum.
- in_valid while in_ready=0 is ignored. Input is not captured, and the upstream must hold it.
- out_ready while out_valid=0 is ignored.
- data_out is driven from result_reg at all times. Only its value while out_valid=1 is architecturally defined; it is never updated mid-DONE.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, col_cnt=0, state_reg=0.
- Reset mid-operation (BUSY or DONE): aborts immediately, the partial result is discarded, and all outputs take their reset values on the next edge.

Optional Feature:
- Macro: INV_SHIFT_SUB_DUAL_COL_EN.
- Defined:
  - Eight inverse S-boxes.
  - BUSY writes columns {0,1} at E1 and {2,3} at E2; DONE is entered at E2.
  - Latency is 2 cycles and col_cnt steps by 2.
- Undefined: four S-boxes, 4-cycle latency as above.
- Handshake, reset and DONE behaviour are identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> in_ready=1, out_valid=0, data_out=0, busy=0.
- Uniform 0x00: data_in=128'h0 -> out_valid high at E4 (E2 dual), data_out=128'h5252...52 (all 0x52).
- Uniform 0x63: data_in all 0x63 -> data_out=128'h0.
- Positional shift check:
  - data_in=128'h637c777b_f26b6fc5_3001672b_fed7ab76
  - -> data_out=128'h000d0a07_04010e0b_0805020f_0c090603.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, data_out constant, in_ready=0, and a new in_valid is not captured.
  - Then out_ready=1 -> IDLE next cycle.
- Reset mid-BUSY: assert rst at E2 after accept -> out_valid never rises, state is IDLE, data_out=0. A following state is processed correctly from column 0.
